voltage_ramp_gen: RTL
=====================

Name: voltage_ramp_gen

Overview:
- Consumes the divided clock produced by the frequency divider stage and treats it as the ramp-rate tick.
- Walks a DAC output code from its current value toward a requested target, moving a programmable step on each tick.
- Used to slew the DE1-SoC output voltage gradually instead of jumping it.
- Fully synchronous to clock_in; the tick input is treated as asynchronous and is synchronised internally.

Parameters:
- DATA_W, 12, width of the DAC code and target.
- STEP_W, 8, width of the step-size input.
- RESET_CODE, 0, dac_code value after reset.
- SYNC_STAGES, 2, flip-flop stages in the tick synchroniser (minimum 2).

Ports:
- clock_in  input  1  system clock, 50 MHz.
- reset  input  1  synchronous, active-high reset.
- tick_in  input  1  divided clock from the divider; each rising edge is one ramp step.
- start  input  1  one-cycle request; latches target_code and step_size.
- target_code  input  DATA_W  requested final DAC code.
- step_size  input  STEP_W  code increment per tick; 0 is treated as 1.
- dac_code  output  DATA_W  current output code (registered).
- busy  output  1  high while ramping.
- done  output  1  one-cycle pulse when dac_code reaches the target.
- ramp_up  output  1  direction of the active ramp: 1 = increasing, 0 = decreasing.

Behaviour:
- Reset, while reset is high at a clock_in edge:
  - dac_code = RESET_CODE; busy = 0; done = 0; ramp_up = 0.
  - State = IDLE; synchroniser flops = 0; latched target = RESET_CODE; latched step = 1.
- Tick detection:
  - tick_in passes through SYNC_STAGES flops, then a rising-edge detector.
  - tick_evt is high for exactly one clock_in cycle per tick_in rising edge.
  - Latency from the tick_in edge to tick_evt is SYNC_STAGES+1 cycles.
  - A falling edge produces no event.
- States: IDLE, RAMP, HOLD.
- IDLE/HOLD with start=1:
  - Latch target_code, and step_size (forced to 1 if 0).
  - If target == dac_code: stay in or enter HOLD and pulse done on the next cycle; busy stays 0.
  - Otherwise: next cycle busy=1, ramp_up = (target > dac_code), state = RAMP.
- RAMP with tick_evt=1:
  - Compute diff = |target − dac_code| at DATA_W+1 bits, no wrap.
  - If diff <= step: dac_code = target, state = HOLD, busy = 0, and done = 1 in that same cycle.
  - Otherwise: dac_code ± step.
  - dac_code therefore never overshoots the target and never wraps past 0 or 2^DATA_W−1.
- RAMP with start=1 (retarget):
  - Latch the new target and step, and recompute ramp_up.
  - Stay in RAMP; dac_code is unchanged that cycle.
  - If the new target equals dac_code: go to HOLD with done pulsed next cycle.
- RAMP with start and tick_evt in the same cycle: start wins; the tick is discarded.
- HOLD: dac_code is held; done falls after one cycle; wait for start.
- IDLE is used only after reset; behaviour in IDLE otherwise matches HOLD.
- Reset mid-ramp: returns to the full reset state on the next edge; no done pulse.
- dac_code changes only on tick_evt cycles (or reset). Step latency is one cycle after tick_evt.
- tick_in stuck high or low: no steps are taken; busy stays 1 in RAMP.

Decomposition:
- Shared package voltage_ctrl_pkg contains:
  - the state enum (IDLE, RAMP, HOLD);
  - the default widths DAC_W=12 and STEP_W=8;
  - the RESET_CODE default.
- One sub-module: tick_sync, holding the SYNC_STAGES synchroniser plus the rising-edge detector and outputting tick_evt. It is reused by other blocks that consume the divider output.

Test Plan:
1. Reset, then start with target=100, step=10, tick_in toggling every 20 cycles:
   - ramp_up=1; dac_code steps 10, 20 … 100 (exactly 10 steps).
   - done pulses once, in the cycle dac_code becomes 100; busy then falls.
2. From dac_code=100, start target=5, step=30:
   - dac_code goes 70, 40, 10, then 5 (final partial step).
   - ramp_up=0; done pulses once.
3. Start with target equal to dac_code (100):
   - busy never rises; done pulses once, 1 cycle after start.
4. step_size=0 with target=3 from 0:
   - dac_code goes 1, 2, 3 over three ticks.
5. Retarget mid-ramp (0→200 with step=50; at dac_code=100, start target=0):
   - dac_code holds 100 that cycle, then steps 50, 0; ramp_up flips to 0.
   - Start coincident with tick_evt: no step taken.
6. Reset asserted at dac_code=60 mid-ramp:
   - Next edge gives dac_code=RESET_CODE, busy=0, no done pulse.
   - tick_in pulses with no start afterwards leave dac_code unchanged.

Source files
------------

// File: rtl/voltage_ctrl_pkg.sv
// Shared definitions for the voltage control path: ramp FSM states and default widths.
package voltage_ctrl_pkg;

  localparam int DAC_W      = 12;
  localparam int STEP_W     = 8;
  localparam int RESET_CODE = 0;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    HOLD
  } state_e;

endpackage

// File: rtl/tick_sync.sv
// Synchronises the divider's tick into the local clock domain and emits a
// one-cycle event per rising edge, SYNC_STAGES+1 cycles after the edge.
module tick_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  output logic tick_evt_o
);

  // Anything shorter than two flops is not a synchroniser.
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              evt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      evt_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], tick_i};
      prev_q <= sync_q[STAGES-1];
      evt_q  <= sync_q[STAGES-1] & ~prev_q;
    end
  end

  assign tick_evt_o = evt_q;

endmodule

// File: rtl/voltage_ramp_gen.sv
// Slews a DAC code toward a requested target by a programmable step per
// divider tick, never overshooting the target or wrapping the code.
module voltage_ramp_gen #(
  parameter int DATA_W      = voltage_ctrl_pkg::DAC_W,
  parameter int STEP_W      = voltage_ctrl_pkg::STEP_W,
  parameter int RESET_CODE  = voltage_ctrl_pkg::RESET_CODE,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic              tick_in,
  input  logic              start,
  input  logic [DATA_W-1:0] target_code,
  input  logic [STEP_W-1:0] step_size,
  output logic [DATA_W-1:0] dac_code,
  output logic              busy,
  output logic              done,
  output logic              ramp_up
);

  import voltage_ctrl_pkg::*;

  // One extra bit so the distance and step compare without wrap.
  localparam int CMP_W = ((DATA_W > STEP_W) ? DATA_W : STEP_W) + 1;
  localparam logic [DATA_W-1:0] RESET_VAL = DATA_W'(RESET_CODE);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] dac_q, dac_d;
  logic [DATA_W-1:0] target_q, target_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ramp_up_q, ramp_up_d;

  logic              tick_evt;
  logic [STEP_W-1:0] step_in;
  logic [CMP_W-1:0]  diff;
  logic [CMP_W-1:0]  step_ext;

  tick_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_tick_sync (
    .clk_i      (clock_in),
    .rst_i      (reset),
    .tick_i     (tick_in),
    .tick_evt_o (tick_evt)
  );

  assign step_in  = (step_size == '0) ? STEP_W'(1) : step_size;
  assign step_ext = CMP_W'(step_q);
  assign diff     = (target_q >= dac_q) ? (CMP_W'(target_q) - CMP_W'(dac_q))
                                        : (CMP_W'(dac_q) - CMP_W'(target_q));

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q   <= IDLE;
      dac_q     <= RESET_VAL;
      target_q  <= RESET_VAL;
      step_q    <= STEP_W'(1);
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ramp_up_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dac_q     <= dac_d;
      target_q  <= target_d;
      step_q    <= step_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ramp_up_q <= ramp_up_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dac_d     = dac_q;
    target_d  = target_q;
    step_d    = step_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ramp_up_d = ramp_up_q;

    // A request is honoured identically in every state and beats a same-cycle tick.
    if (start) begin
      target_d = target_code;
      step_d   = step_in;
      if (target_code == dac_q) begin
        state_d = HOLD;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        state_d   = RAMP;
        busy_d    = 1'b1;
        ramp_up_d = (target_code > dac_q);
      end
    end else begin
      case (state_q)
        RAMP: begin
          if (tick_evt) begin
            if (diff <= step_ext) begin
              dac_d   = target_q;
              state_d = HOLD;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else if (ramp_up_q) begin
              dac_d = dac_q + DATA_W'(step_q);
            end else begin
              dac_d = dac_q - DATA_W'(step_q);
            end
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  assign dac_code = dac_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ramp_up  = ramp_up_q;

endmodule
